// File: rtl/data_mem_unit.sv
//------------------------------------------------------------------------------
// Module   : data_mem_unit
// Function : Data-side RAM with byte-lane stores, load extension and a
//            16-byte MMIO window (GPIO, CYCLE, TIMER_CMP, STATUS).
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module data_mem_unit #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE   = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemWriteM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [2:0]  funct3M,
    output logic [31:0] ReadData,
    output logic [31:0] gpio_out,
    output logic        timer_irq,
    output logic        misalign_err
);

    localparam int          c_AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] c_RAM_BYTES = 32'(DEPTH_WORDS * 4);

    localparam logic [2:0] c_F3_B  = 3'b000;
    localparam logic [2:0] c_F3_H  = 3'b001;
    localparam logic [2:0] c_F3_W  = 3'b010;
    localparam logic [2:0] c_F3_BU = 3'b100;
    localparam logic [2:0] c_F3_HU = 3'b101;

    localparam logic [1:0] c_OFF_GPIO   = 2'd0;
    localparam logic [1:0] c_OFF_CYCLE  = 2'd1;
    localparam logic [1:0] c_OFF_CMP    = 2'd2;
    localparam logic [1:0] c_OFF_STATUS = 2'd3;

    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_gpio;
    logic [31:0] r_cycle;
    logic [31:0] r_cmp;
    logic        r_status;
    logic        r_misalign;

    logic            w_ramHit;
    logic            w_mmioHit;
    logic [c_AW-1:0] w_wordIdx;
    logic [1:0]      w_mmioOff;
    logic [1:0]      w_byteOff;
    logic [31:0]     w_word;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic            w_misaligned;
    logic [3:0]      w_be;
    logic [31:0]     w_wdata;
    logic            w_ramWr;
    logic            w_mmioWr;
    logic            w_match;

    assign w_ramHit  = (ALUResultM < c_RAM_BYTES);
    assign w_mmioHit = (ALUResultM[31:4] == MMIO_BASE[31:4]);
    assign w_wordIdx = ALUResultM[c_AW+1:2];
    assign w_mmioOff = ALUResultM[3:2];
    assign w_byteOff = ALUResultM[1:0];

    // Word select, then lane extraction shared by RAM and MMIO reads
    always_comb begin
        w_word = 32'd0;
        if (w_ramHit) begin
            w_word = r_mem[w_wordIdx];
        end else if (w_mmioHit) begin
            case (w_mmioOff)
                c_OFF_GPIO:   w_word = r_gpio;
                c_OFF_CYCLE:  w_word = r_cycle;
                c_OFF_CMP:    w_word = r_cmp;
                c_OFF_STATUS: w_word = {31'd0, r_status};
                default:      w_word = 32'd0;
            endcase
        end
    end

    always_comb begin
        w_byte = 8'd0;
        case (w_byteOff)
            2'd0:    w_byte = w_word[7:0];
            2'd1:    w_byte = w_word[15:8];
            2'd2:    w_byte = w_word[23:16];
            default: w_byte = w_word[31:24];
        endcase
    end

    assign w_half = ALUResultM[1] ? w_word[31:16] : w_word[15:0];

    always_comb begin
        ReadData = 32'd0;
        case (funct3M)
            c_F3_B:  ReadData = {{24{w_byte[7]}}, w_byte};
            c_F3_BU: ReadData = {24'd0, w_byte};
            c_F3_H:  ReadData = {{16{w_half[15]}}, w_half};
            c_F3_HU: ReadData = {16'd0, w_half};
            c_F3_W:  ReadData = w_word;
            default: ReadData = 32'd0;
        endcase
    end

    assign w_misaligned = MemWriteM &&
                          (((funct3M == c_F3_H) && ALUResultM[0]) ||
                           ((funct3M == c_F3_W) && (w_byteOff != 2'd0)));

    always_comb begin
        w_be    = 4'b0000;
        w_wdata = WriteDataM;
        case (funct3M)
            c_F3_B: begin
                w_be    = 4'b0001 << w_byteOff;
                w_wdata = {4{WriteDataM[7:0]}};
            end
            c_F3_H: begin
                w_be    = ALUResultM[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{WriteDataM[15:0]}};
            end
            c_F3_W: begin
                w_be    = 4'b1111;
                w_wdata = WriteDataM;
            end
            default: begin
                w_be    = 4'b0000;
                w_wdata = WriteDataM;
            end
        endcase
    end

    assign w_ramWr  = MemWriteM && w_ramHit && !w_misaligned && !rst;
    // Peripheral registers only accept full aligned words
    assign w_mmioWr = MemWriteM && w_mmioHit && (funct3M == c_F3_W) &&
                      (w_byteOff == 2'd0);
    assign w_match  = (r_cycle == r_cmp);

    always_ff @(posedge clk) begin
        if (w_ramWr) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_wordIdx][8*b +: 8] <= w_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gpio     <= 32'd0;
            r_cycle    <= 32'd0;
            r_cmp      <= 32'hFFFF_FFFF;
            r_status   <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= w_misaligned;
            if (w_mmioWr && (w_mmioOff == c_OFF_GPIO)) begin
                r_gpio <= WriteDataM;
            end
            if (w_mmioWr && (w_mmioOff == c_OFF_CYCLE)) begin
                r_cycle <= WriteDataM;
            end else begin
                r_cycle <= r_cycle + 32'd1;
            end
            if (w_mmioWr && (w_mmioOff == c_OFF_CMP)) begin
                r_cmp <= WriteDataM;
            end
            // A match in the same cycle as a clear leaves the flag set
            if (w_match) begin
                r_status <= 1'b1;
            end else if (w_mmioWr && (w_mmioOff == c_OFF_STATUS) && WriteDataM[0]) begin
                r_status <= 1'b0;
            end
        end
    end

    assign gpio_out     = r_gpio;
    assign timer_irq    = r_status;
    assign misalign_err = r_misalign;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_unit.sv
//------------------------------------------------------------------------------
// Module   : tb_data_mem_unit
// Function : Directed self-checking bench for data_mem_unit.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_data_mem_unit;

    localparam logic [31:0] c_GPIO   = 32'h8000_0000;
    localparam logic [31:0] c_CYCLE  = 32'h8000_0004;
    localparam logic [31:0] c_CMP    = 32'h8000_0008;
    localparam logic [31:0] c_STATUS = 32'h8000_000C;

    logic        clk;
    logic        rst;
    logic        MemWriteM;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [2:0]  funct3M;
    logic [31:0] ReadData;
    logic [31:0] gpio_out;
    logic        timer_irq;
    logic        misalign_err;

    int nTests = 0;
    int nFail  = 0;

    data_mem_unit #(
        .DEPTH_WORDS (1024),
        .MMIO_BASE   (32'h8000_0000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .MemWriteM    (MemWriteM),
        .ALUResultM   (ALUResultM),
        .WriteDataM   (WriteDataM),
        .funct3M      (funct3M),
        .ReadData     (ReadData),
        .gpio_out     (gpio_out),
        .timer_irq    (timer_irq),
        .misalign_err (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nTests++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are retired just after the edge
    task automatic next();
        @(posedge clk);
        #1;
        MemWriteM = 1'b0;
    endtask

    task automatic drive(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data);
        MemWriteM  = 1'b1;
        funct3M    = f3;
        ALUResultM = addr;
        WriteDataM = data;
        #1;
    endtask

    task automatic store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data);
        drive(f3, addr, data);
        next();
    endtask

    task automatic load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] exp);
        MemWriteM  = 1'b0;
        funct3M    = f3;
        ALUResultM = addr;
        #1;
        check(tag, ReadData, exp);
    endtask

    initial begin
        rst        = 1'b1;
        MemWriteM  = 1'b0;
        funct3M    = 3'b010;
        ALUResultM = 32'd0;
        WriteDataM = 32'd0;

        // Reset, with a GPIO store attempted while reset is held
        @(posedge clk);
        #1;
        drive(3'b010, c_GPIO, 32'hFFFF_FFFF);
        @(posedge clk);
        #1;
        MemWriteM = 1'b0;
        rst       = 1'b0;
        check("rst_gpio", gpio_out, 32'd0);
        check("rst_irq", {31'd0, timer_irq}, 32'd0);
        check("rst_misalign", {31'd0, misalign_err}, 32'd0);
        load("rst_cmp", 3'b010, c_CMP, 32'hFFFF_FFFF);
        load("rst_status", 3'b010, c_STATUS, 32'd0);
        load("rst_cycle0", 3'b010, c_CYCLE, 32'd0);
        next();
        load("rst_cycle1", 3'b010, c_CYCLE, 32'd1);
        next();
        load("rst_cycle2", 3'b010, c_CYCLE, 32'd2);

        // Byte/half lane extraction
        store(3'b010, 32'h10, 32'h8081_7F01);
        load("lb_11", 3'b000, 32'h11, 32'h0000_007F);
        load("lb_13", 3'b000, 32'h13, 32'hFFFF_FF80);
        load("lbu_13", 3'b100, 32'h13, 32'h0000_0080);
        load("lh_12", 3'b001, 32'h12, 32'hFFFF_8081);
        load("lhu_10", 3'b101, 32'h10, 32'h0000_7F01);
        load("lh_13", 3'b001, 32'h13, 32'hFFFF_8081);
        load("lw_11", 3'b010, 32'h11, 32'h8081_7F01);
        load("f3_011", 3'b011, 32'h10, 32'd0);
        load("f3_111", 3'b111, 32'h10, 32'd0);

        // Partial stores
        store(3'b010, 32'h20, 32'hAABB_CCDD);
        store(3'b000, 32'h22, 32'h0000_0011);
        store(3'b001, 32'h20, 32'h0000_2233);
        load("partial", 3'b010, 32'h20, 32'hAA11_2233);
        store(3'b011, 32'h20, 32'h0000_0000);
        load("f3_011_store", 3'b010, 32'h20, 32'hAA11_2233);

        // RAM boundary: last word in range, first word out of range
        store(3'b010, 32'h0, 32'hCAFE_BABE);
        store(3'b010, 32'hFFC, 32'h1357_9BDF);
        store(3'b010, 32'h1000, 32'h0BAD_0BAD);
        load("ram_last", 3'b010, 32'hFFC, 32'h1357_9BDF);
        load("ram_oob", 3'b010, 32'h1000, 32'd0);
        load("ram_0", 3'b010, 32'h0, 32'hCAFE_BABE);

        // Misaligned stores
        store(3'b010, 32'h24, 32'h1234_5678);
        drive(3'b010, 32'h26, 32'hDEAD_BEEF);
        check("mis_pre", {31'd0, misalign_err}, 32'd0);
        next();
        check("mis_pulse", {31'd0, misalign_err}, 32'd1);
        load("mis_word", 3'b010, 32'h24, 32'h1234_5678);
        next();
        check("mis_clear", {31'd0, misalign_err}, 32'd0);
        store(3'b001, 32'h25, 32'h0000_FFFF);
        check("mis_sh", {31'd0, misalign_err}, 32'd1);
        store(3'b010, 32'h27, 32'h0000_0000);
        check("mis_b2b", {31'd0, misalign_err}, 32'd1);
        load("mis_word2", 3'b010, 32'h24, 32'h1234_5678);
        next();
        check("mis_end", {31'd0, misalign_err}, 32'd0);

        // GPIO: SB ignored, SW honoured, read-during-write shows old data
        store(3'b000, c_GPIO, 32'h0000_00FF);
        check("gpio_sb", gpio_out, 32'd0);
        check("gpio_sb_err", {31'd0, misalign_err}, 32'd0);
        drive(3'b010, c_GPIO, 32'h5A5A_0001);
        check("rdw_old", ReadData, 32'd0);
        check("gpio_pre", gpio_out, 32'd0);
        next();
        check("gpio_sw", gpio_out, 32'h5A5A_0001);
        load("gpio_rd", 3'b010, c_GPIO, 32'h5A5A_0001);
        load("gpio_lbu", 3'b100, 32'h8000_0003, 32'h0000_005A);
        load("unmapped", 3'b010, 32'h4000_0000, 32'd0);

        // Timer compare
        store(3'b010, c_CYCLE, 32'd5);
        store(3'b010, c_CMP, 32'd20);
        load("cyc_6", 3'b010, c_CYCLE, 32'd6);
        repeat (14) next();
        load("cyc_20", 3'b010, c_CYCLE, 32'd20);
        check("irq_pre", {31'd0, timer_irq}, 32'd0);
        next();
        check("irq_rise", {31'd0, timer_irq}, 32'd1);
        load("status_set", 3'b010, c_STATUS, 32'd1);
        store(3'b010, c_CMP, 32'd25);
        repeat (3) next();
        load("cyc_25", 3'b010, c_CYCLE, 32'd25);
        store(3'b010, c_STATUS, 32'd1);
        check("w1c_vs_match", {31'd0, timer_irq}, 32'd1);
        store(3'b010, c_STATUS, 32'd1);
        check("w1c_clear", {31'd0, timer_irq}, 32'd0);
        store(3'b010, c_CMP, 32'd29);
        next();
        load("cyc_29", 3'b010, c_CYCLE, 32'd29);
        store(3'b010, c_CMP, 32'hFFFF_FFF0);
        check("cmp_wr_match", {31'd0, timer_irq}, 32'd1);
        store(3'b010, c_STATUS, 32'd1);
        check("w1c_clear2", {31'd0, timer_irq}, 32'd0);
        load("status_clr", 3'b010, c_STATUS, 32'd0);

        // CYCLE wrap
        store(3'b010, c_CYCLE, 32'hFFFF_FFFE);
        load("wrap_fe", 3'b010, c_CYCLE, 32'hFFFF_FFFE);
        next();
        load("wrap_ff", 3'b010, c_CYCLE, 32'hFFFF_FFFF);
        next();
        load("wrap_0", 3'b010, c_CYCLE, 32'd0);
        next();
        load("wrap_1", 3'b010, c_CYCLE, 32'd1);

        // Reset coinciding with a RAM store drops the store, keeps RAM
        store(3'b010, 32'h30, 32'h1111_1111);
        rst = 1'b1;
        drive(3'b010, 32'h30, 32'h2222_2222);
        next();
        rst = 1'b0;
        load("rst_store", 3'b010, 32'h30, 32'h1111_1111);
        load("rst_keep_ram", 3'b010, 32'h10, 32'h8081_7F01);
        check("rst2_gpio", gpio_out, 32'd0);
        load("rst2_cmp", 3'b010, c_CMP, 32'hFFFF_FFFF);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/data_mem_unit.md
Name: data_mem_unit

Overview:
Data-side memory block sitting directly downstream of the pipelined RV32I core's Memory stage. It consumes the core's store/address/funct3 outputs and returns load data to the Writeback path. It provides word-addressed RAM with byte-lane stores, load sign/zero extension, and a small memory-mapped peripheral window. The window holds a GPIO register, a free-running cycle counter, a compare timer and a sticky status register.

Parameters:
DEPTH_WORDS, 1024, RAM size in 32-bit words (power of two); RAM occupies byte addresses 0 .. DEPTH_WORDS*4-1
MMIO_BASE, 32'h8000_0000, base byte address of the 16-byte peripheral window

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
MemWriteM  input  1  store enable from Memory stage
ALUResultM  input  32  byte address
WriteDataM  input  32  store data (unshifted, LSB-aligned)
funct3M  input  3  RV32I load/store width and sign code
ReadData  output  32  extended load data, combinational from address/funct3
gpio_out  output  32  GPIO register value
timer_irq  output  1  level, equals STATUS[0]
misalign_err  output  1  one-cycle pulse, registered, flags a suppressed misaligned store

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values:
  - gpio_out=0, CYCLE=0, TIMER_CMP=32'hFFFF_FFFF, STATUS=0, misalign_err=0, timer_irq=0.
  - RAM contents are not affected by rst.
  - rst asserted in the same cycle as a store: the store is dropped and the registers take their reset values.
- Address decode:
  - RAM hit when ALUResultM < DEPTH_WORDS*4; word index = ALUResultM[log2(DEPTH_WORDS)+1:2].
  - MMIO hit when ALUResultM[31:4] == MMIO_BASE[31:4]. Offsets:
    - 0x0 GPIO (R/W)
    - 0x4 CYCLE (R/W)
    - 0x8 TIMER_CMP (R/W)
    - 0xC STATUS (bit0 = timer match; write-1-to-clear; bits 31:1 read 0)
  - Any other address: reads return 0, stores are ignored, no error.
- Loads are combinational with zero latency; the word is selected by address, then the lane is extracted and extended:
  - 000 LB: byte at addr[1:0], sign-extended
  - 100 LBU: byte at addr[1:0], zero-extended
  - 001 LH: halfword at addr[1], sign-extended; addr[0] ignored
  - 101 LHU: halfword at addr[1], zero-extended; addr[0] ignored
  - 010 LW: addr[1:0] ignored
  - 011, 110, 111: ReadData=0
  - MMIO reads use the same extraction.
- Stores commit at the rising edge when MemWriteM=1:
  - 000 SB: WriteDataM[7:0] to lane addr[1:0]
  - 001 SH: WriteDataM[15:0] to lanes {addr[1],0} and {addr[1],1}
  - 010 SW: all lanes
  - Other funct3 codes: no write.
  - Misaligned store (SH with addr[0]=1, or SW with addr[1:0]!=0): no write, to RAM or MMIO; misalign_err=1 in the following cycle only.
  - Back-to-back misaligned stores give consecutive pulses.
- MMIO stores: only aligned SW is honoured. SB/SH to MMIO are ignored with no error.
- Read-during-write to the same address: ReadData shows the old data in that cycle and the new data from the next cycle.
- CYCLE counter:
  - CYCLE <= CYCLE+1 each cycle, wrapping 32'hFFFF_FFFF to 0.
  - An SW to CYCLE loads WriteDataM instead of incrementing.
- Timer match:
  - Compare uses the pre-edge values: if CYCLE==TIMER_CMP, STATUS[0] <= 1.
  - A W1C write to STATUS with bit0=1 clears STATUS[0]; if a match occurs in the same cycle, the set wins.
  - A write to TIMER_CMP or CYCLE in the matching cycle does not cancel that match.
- Sizing: the RAM is inferred as one 32-bit array with per-byte write enables; no other storage.

Test Plan:
- Reset: rst=1 for 2 cycles -> gpio_out=0, timer_irq=0, misalign_err=0; LW of 0x8000_0004 one cycle after release returns 1, two cycles after returns 2.
- Byte/half lanes: SW 0x0000_0010 <= 0x8081_7F01; then LB 0x11 -> 0x0000_007F, LB 0x13 -> 0xFFFF_FF80, LBU 0x13 -> 0x0000_0080, LH 0x12 -> 0xFFFF_8081, LHU 0x10 -> 0x0000_7F01.
- Partial store: SW 0x20 <= 0xAABBCCDD; SB 0x22 <= 0x11; SH 0x20 <= 0x2233 -> LW 0x20 = 0xAA112233.
- Misaligned store: SW 0x24 <= 0x12345678; then SW 0x26 <= 0xDEADBEEF -> word unchanged; misalign_err high exactly one cycle after. SH 0x25 -> same pulse, no write.
- Timer: SW TIMER_CMP <= 20 while CYCLE<20 -> timer_irq rises the cycle after CYCLE==20. A W1C coinciding with a new match keeps it set; a later W1C clears it.
- Wrap/MMIO: SW CYCLE <= 0xFFFF_FFFE -> reads 0xFFFF_FFFF, then 0, then 1. SB to GPIO is ignored. SW GPIO <= 0x5A5A_0001 -> gpio_out updates next cycle. Load from 0x4000_0000 -> 0.
